// File: rtl/rv_muldiv_iter_if.sv
// rv_muldiv_iter_if: handshake/operand bundle between the core control FSM
// (master) and the iterative RV32M multiply/divide unit (slave).
//   start  : launch an op (taken only when the unit is idle or just finished)
//   kill   : synchronous abort of the op in flight (pipeline flush)
//   op     : RISC-V funct3 of the M-extension instruction
//   opa    : rs1 value (multiplicand / dividend)
//   opb    : rs2 value (multiplier / divisor)
//   busy   : op in flight
//   done   : one-cycle pulse, result valid
//   result : registered result, held until overwritten by a later op
interface rv_muldiv_iter_if #(
  parameter int DPWIDTH = 32
);
  logic               start;
  logic               kill;
  logic [2:0]         op;
  logic [DPWIDTH-1:0] opa;
  logic [DPWIDTH-1:0] opb;
  logic               busy;
  logic               done;
  logic [DPWIDTH-1:0] result;

  modport master (
    output start, kill, op, opa, opb,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, opa, opb,
    output busy, done, result
  );
endinterface

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: iterative RV32M multiply/divide execute unit.
// Works on operand magnitudes, retiring UNROLL bits per ITER cycle
// (shift-add multiply or restoring divide sharing one 2*DPWIDTH accumulator),
// then applies sign correction and selects the result in a single FIX cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rv_muldiv_iter_if slave modport (start/kill/op/opa/opb in,
//          busy/done/result out)
module rv_muldiv_iter #(
  parameter int DPWIDTH = 32,
  parameter int UNROLL  = 1
) (
  input  logic            clk,
  input  logic            rst,
  rv_muldiv_iter_if.slave bus
);

  localparam int N  = DPWIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [DPWIDTH-1:0] MIN_VAL = {1'b1, {(DPWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [2*DPWIDTH-1:0] acc_q, acc_d;
  logic [DPWIDTH-1:0]   opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DPWIDTH-1:0]   result_q, result_d;

  // Start-time decode of the incoming operands.
  logic               accept;
  logic               special_in;
  logic               sa_in, sb_in, neg_in;
  logic [DPWIDTH-1:0] abs_a, abs_b, special_res;

  always_comb begin
    accept     = (state_q == S_IDLE || state_q == S_DONE) && bus.start && !bus.kill;
    // Divide by zero and MIN/-1 need no iteration: the answer is fixed.
    special_in = bus.op[2] && ((bus.opb == '0) ||
                 (!bus.op[0] && bus.opa == MIN_VAL && bus.opb == '1));
    if (bus.opb == '0) special_res = bus.op[1] ? bus.opa : '1;
    else               special_res = bus.op[1] ? '0 : MIN_VAL;
    sa_in  = bus.opa[DPWIDTH-1] && (bus.op == 3'b001 || bus.op == 3'b010 ||
                                    bus.op == 3'b100 || bus.op == 3'b110);
    sb_in  = bus.opb[DPWIDTH-1] && (bus.op == 3'b001 || bus.op == 3'b100 ||
                                    bus.op == 3'b110);
    // Remainder follows the dividend sign; everything else is sign xor.
    neg_in = (bus.op == 3'b110) ? sa_in : (sa_in ^ sb_in);
    abs_a  = sa_in ? -bus.opa : bus.opa;
    abs_b  = sb_in ? -bus.opb : bus.opb;
  end

  // Unrolled iteration chain. Accumulator layout: hi half = partial product
  // or partial remainder, lo half = remaining multiplier bits or
  // dividend bits being shifted out while quotient bits shift in.
  logic [2*DPWIDTH-1:0] stage_acc [0:UNROLL];
  assign stage_acc[0] = acc_q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      logic [DPWIDTH:0]     rem_sh, rem_sub, hi_sum;
      logic [2*DPWIDTH-1:0] div_nxt, mul_nxt;

      assign rem_sh  = {stage_acc[gi][2*DPWIDTH-1:DPWIDTH], stage_acc[gi][DPWIDTH-1]};
      assign rem_sub = rem_sh - {1'b0, opnd_q};
      // rem_sub's top bit is the borrow: divisor did not fit, restore.
      assign div_nxt = rem_sub[DPWIDTH]
                     ? {rem_sh[DPWIDTH-1:0],  stage_acc[gi][DPWIDTH-2:0], 1'b0}
                     : {rem_sub[DPWIDTH-1:0], stage_acc[gi][DPWIDTH-2:0], 1'b1};
      assign hi_sum  = {1'b0, stage_acc[gi][2*DPWIDTH-1:DPWIDTH]} +
                       (stage_acc[gi][0] ? {1'b0, opnd_q} : {(DPWIDTH+1){1'b0}});
      assign mul_nxt = {hi_sum, stage_acc[gi][DPWIDTH-1:1]};
      assign stage_acc[gi+1] = op_q[2] ? div_nxt : mul_nxt;
    end
  endgenerate

  // Sign correction and result selection for the FIX cycle.
  logic [2*DPWIDTH-1:0] prod_fix;
  logic [DPWIDTH-1:0]   quot, remv, fix_res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot     = acc_q[DPWIDTH-1:0];
    remv     = acc_q[2*DPWIDTH-1:DPWIDTH];
    case (op_q)
      3'b000:                 fix_res = prod_fix[DPWIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*DPWIDTH-1:DPWIDTH];
      3'b100, 3'b101:         fix_res = neg_q ? -quot : quot;
      default:                fix_res = neg_q ? -remv : remv;
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. Kill beats everything, including a coincident start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.kill)       state_d = S_IDLE;
        else if (bus.start) state_d = special_in ? S_DONE : S_ITER;
        else                state_d = S_IDLE;
      end
      S_ITER: begin
        if (bus.kill)              state_d = S_IDLE;
        else if (cnt_q == CW'(1))  state_d = S_FIX;
      end
      S_FIX:   state_d = bus.kill ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    bus.busy   = (state_q == S_ITER) || (state_q == S_FIX);
    bus.done   = (state_q == S_DONE);
    bus.result = result_q;
  end

  // Datapath next state.
  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d   = bus.op;
          neg_d  = neg_in;
          cnt_d  = CW'(N);
          acc_d  = {{DPWIDTH{1'b0}}, (bus.op[2] ? abs_a : abs_b)};
          opnd_d = bus.op[2] ? abs_b : abs_a;
          if (special_in) result_d = special_res;
        end
      end
      S_ITER: begin
        if (!bus.kill) begin
          acc_d = stage_acc[UNROLL];
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        if (!bus.kill) result_d = fix_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
